// File: rtl/keyboard_pkg.sv
// Shared constants, cell state encoding and note encoder for the key conditioner.
package keyboard_pkg;

  localparam int unsigned NUM_NOTE_KEYS           = 7;
  localparam int unsigned NUM_OCT_KEYS            = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 2_000_000;
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
  localparam int unsigned REPEAT_CYCLES_DEFAULT   = 25_000_000;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SOL  = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_TI   = 4'd7;

  typedef enum logic [1:0] {
    RELEASED,
    ARMING,
    HELD,
    DISARMING
  } cell_state_e;

  // Index+1 of the lowest held key; NOTE_NONE when nothing is held.
  function automatic logic [3:0] encode_note(input logic [NUM_NOTE_KEYS-1:0] keys);
    logic [3:0] code;
    code = NOTE_NONE;
    for (int i = NUM_NOTE_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) code = 4'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/note_key_conditioner_if.sv
// Raw button inputs and conditioned key outputs of the note key conditioner.
interface note_key_conditioner_if;
  import keyboard_pkg::*;

  logic [NUM_NOTE_KEYS-1:0] key_raw;
  logic [NUM_OCT_KEYS-1:0]  octave_raw;
  logic [NUM_NOTE_KEYS-1:0] key_stable;
  logic [NUM_OCT_KEYS-1:0]  octave_stable;
  logic [3:0]               note_code;
  logic                     press_pulse;
  logic                     release_pulse;
  logic                     any_key;

  // Board / stimulus side: drives raw buttons, observes conditioned keys.
  modport master (
    output key_raw, octave_raw,
    input  key_stable, octave_stable, note_code, press_pulse, release_pulse, any_key
  );

  // Conditioner side.
  modport slave (
    input  key_raw, octave_raw,
    output key_stable, octave_stable, note_code, press_pulse, release_pulse, any_key
  );

endinterface

// File: rtl/key_debounce_cell.sv
// One-bit synchronizer + debounce FSM. stable_o is the next-state value of the
// debounced bit; the parent registers it so that all strobes land in the same cycle.
module key_debounce_cell
  import keyboard_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam int unsigned   CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  cell_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;

  // Shift the raw button through the synchronizer chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Saturating increment; the FSM leaves the counting state before it matters.
  assign cnt_inc = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + 1'b1;

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce transitions: a change is accepted once the counter reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (synced) begin
          state_d = ARMING;
          cnt_d   = '0;
        end
      end
      ARMING: begin
        if (!synced) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_DONE) state_d = HELD;
        end
      end
      HELD: begin
        if (!synced) begin
          state_d = DISARMING;
          cnt_d   = '0;
        end
      end
      DISARMING: begin
        if (synced) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_DONE) state_d = RELEASED;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign stable_o = (state_d == HELD) || (state_d == DISARMING);

endmodule

// File: rtl/note_key_conditioner.sv
// Conditions 7 note keys and 2 octave keys: debounce, note encoding and press/release
// strobes. Optional auto-repeat of press_pulse under `define KEY_REPEAT_EN.
module note_key_conditioner
  import keyboard_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  note_key_conditioner_if.slave  kbd
);

  localparam int unsigned NUM_KEYS = NUM_NOTE_KEYS + NUM_OCT_KEYS;

  logic [NUM_KEYS-1:0]      raw_all;
  logic [NUM_KEYS-1:0]      stable_next;
  logic [NUM_NOTE_KEYS-1:0] key_q, key_d;
  logic [NUM_OCT_KEYS-1:0]  oct_q, oct_d;
  logic [3:0]               note_q, note_d;
  logic                     press_q, press_d;
  logic                     release_q, release_d;
  logic                     any_q, any_d;
  logic                     rpt_hit;

  assign raw_all = {kbd.octave_raw, kbd.key_raw};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_cell
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (raw_all[i]),
      .stable_o(stable_next[i])
    );
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned         RPT_W    = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0]    RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;

  // Repeat timer: restarts on any note change, idles at zero while no note is held.
  always_comb begin
    rpt_d   = rpt_q;
    rpt_hit = 1'b0;
    if (note_d == NOTE_NONE || note_d != note_q) begin
      rpt_d = '0;
    end else if (rpt_q == RPT_LAST) begin
      rpt_d   = '0;
      rpt_hit = 1'b1;
    end else begin
      rpt_d = rpt_q + 1'b1;
    end
  end

  // Repeat timer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`else
  assign rpt_hit = 1'b0;
`endif

  // Next output values derived from the cells' next debounced state.
  always_comb begin
    key_d     = stable_next[NUM_NOTE_KEYS-1:0];
    oct_d     = stable_next[NUM_KEYS-1:NUM_NOTE_KEYS];
    note_d    = encode_note(key_d);
    any_d     = |key_d;
    press_d   = (|(key_d & ~key_q)) | rpt_hit;
    release_d = (|key_q) & ~any_d;
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q     <= '0;
      oct_q     <= '0;
      note_q    <= NOTE_NONE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      any_q     <= 1'b0;
    end else begin
      key_q     <= key_d;
      oct_q     <= oct_d;
      note_q    <= note_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
    end
  end

  assign kbd.key_stable    = key_q;
  assign kbd.octave_stable = oct_q;
  assign kbd.note_code     = note_q;
  assign kbd.press_pulse   = press_q;
  assign kbd.release_pulse = release_q;
  assign kbd.any_key       = any_q;

endmodule

// File: tb/tb_note_key_conditioner.sv
// Scoreboard bench for note_key_conditioner: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever the outputs change or a strobe fires.
module tb_note_key_conditioner;
  import keyboard_pkg::*;

  localparam int unsigned DB = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned RC = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  note_key_conditioner_if kbd ();

  note_key_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .SYNC_STAGES    (SS),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kbd  (kbd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [6:0] ks;
    logic [1:0] oc;
    logic [3:0] nc;
    logic       p;
    logic       r;
  } ev_t;

  ev_t exp_q[$];

  task automatic expect_ev(input int c, input logic [6:0] ks, input logic [1:0] oc,
                           input logic [3:0] nc, input logic p, input logic r);
    ev_t e;
    e.c  = c;
    e.ks = ks;
    e.oc = oc;
    e.nc = nc;
    e.p  = p;
    e.r  = r;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    logic [15:0] got;
    got = {kbd.key_stable, kbd.octave_stable, kbd.note_code,
           kbd.press_pulse, kbd.release_pulse, kbd.any_key};
    checks++;
    if (got !== 16'h0) begin
      errors++;
      $display("FAIL %s: outputs=%h required 0000", name, got);
    end
  endtask

  // Monitor: any output change or strobe is an event that must match the queue head.
  logic [15:0] mon_prev = '0;
  logic [15:0] mon_cur;
  logic [15:0] mon_exp;
  ev_t         mon_e;

  always @(negedge clk) begin
    mon_cur = {kbd.key_stable, kbd.octave_stable, kbd.note_code,
               kbd.press_pulse, kbd.release_pulse, kbd.any_key};
    if (mon_cur !== mon_prev || kbd.press_pulse === 1'b1 || kbd.release_pulse === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc=%0d ks=%b oc=%b nc=%0d p=%b r=%b any=%b",
                 cyc, kbd.key_stable, kbd.octave_stable, kbd.note_code,
                 kbd.press_pulse, kbd.release_pulse, kbd.any_key);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_exp = {mon_e.ks, mon_e.oc, mon_e.nc, mon_e.p, mon_e.r, |mon_e.ks};
        if (cyc != mon_e.c || mon_cur !== mon_exp) begin
          errors++;
          $display("FAIL event: got cyc=%0d {ks,oc,nc,p,r,any}=%b required cyc=%0d %b",
                   cyc, mon_cur, mon_e.c, mon_exp);
        end
      end
    end
    mon_prev = mon_cur;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    kbd.key_raw    = '0;
    kbd.octave_raw = '0;
    #1 reset = 1'b1;
    step(3);
    check_zero("reset_hold");
    reset = 1'b0;
    step(1);
    check_zero("after_reset");
    step(5);

    // Single key: stable 10 cycles after the raw edge, one press strobe.
    t = cyc;
    kbd.key_raw = 7'b0000100;
    expect_ev(t + 10, 7'b0000100, 2'b00, NOTE_MI, 1'b1, 1'b0);
    expect_ev(t + 11, 7'b0000100, 2'b00, NOTE_MI, 1'b0, 1'b0);
    step(20);
    t = cyc;
    kbd.key_raw = 7'b0;
    expect_ev(t + 10, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b1);
    expect_ev(t + 11, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b0);
    step(25);

    // Bouncing key (3-cycle runs) must never be accepted.
    for (int i = 0; i < 14; i++) begin
      kbd.key_raw[0] = ~kbd.key_raw[0];
      step(3);
    end
    step(20);

    // Two keys at once, then release them one by one.
    t = cyc;
    kbd.key_raw = 7'b0100100;
    expect_ev(t + 10, 7'b0100100, 2'b00, NOTE_MI, 1'b1, 1'b0);
    expect_ev(t + 11, 7'b0100100, 2'b00, NOTE_MI, 1'b0, 1'b0);
    step(20);
    t = cyc;
    kbd.key_raw = 7'b0100000;
    expect_ev(t + 10, 7'b0100000, 2'b00, NOTE_LA, 1'b0, 1'b0);
    step(20);
    t = cyc;
    kbd.key_raw = 7'b0;
    expect_ev(t + 10, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b1);
    expect_ev(t + 11, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b0);
    step(25);

    // Held key with a 4-cycle low glitch stays held.
    t = cyc;
    kbd.key_raw = 7'b0001000;
    expect_ev(t + 10, 7'b0001000, 2'b00, NOTE_FA, 1'b1, 1'b0);
    expect_ev(t + 11, 7'b0001000, 2'b00, NOTE_FA, 1'b0, 1'b0);
    step(20);
    kbd.key_raw = 7'b0;
    step(4);
    kbd.key_raw = 7'b0001000;
    step(16);
    t = cyc;
    kbd.key_raw = 7'b0;
    expect_ev(t + 10, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b1);
    expect_ev(t + 11, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b0);
    step(25);

    // Octave keys: both bits pass through, no strobes.
    t = cyc;
    kbd.octave_raw = 2'b11;
    expect_ev(t + 10, 7'b0, 2'b11, NOTE_NONE, 1'b0, 1'b0);
    step(20);
    t = cyc;
    kbd.octave_raw = 2'b00;
    expect_ev(t + 10, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b0);
    step(25);

    // Asynchronous reset while key 0 is arming and key 6 is held.
    t = cyc;
    kbd.key_raw = 7'b1000000;
    expect_ev(t + 10, 7'b1000000, 2'b00, NOTE_TI, 1'b1, 1'b0);
    expect_ev(t + 11, 7'b1000000, 2'b00, NOTE_TI, 1'b0, 1'b0);
    step(20);
    kbd.key_raw = 7'b1000001;
    step(4);
    #2;
    expect_ev(cyc, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_zero("reset_async");
    step(3);
    t = cyc;
    reset = 1'b0;
    expect_ev(t + 10, 7'b1000001, 2'b00, NOTE_DO, 1'b1, 1'b0);
    expect_ev(t + 11, 7'b1000001, 2'b00, NOTE_DO, 1'b0, 1'b0);
    step(20);
    t = cyc;
    kbd.key_raw = 7'b0;
    expect_ev(t + 10, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b1);
    expect_ev(t + 11, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b0);
    step(25);

    // Long hold of key 1: auto-repeat only when the feature is built in.
    t = cyc;
    kbd.key_raw = 7'b0000010;
    expect_ev(t + 10, 7'b0000010, 2'b00, NOTE_RE, 1'b1, 1'b0);
    expect_ev(t + 11, 7'b0000010, 2'b00, NOTE_RE, 1'b0, 1'b0);
`ifdef KEY_REPEAT_EN
    expect_ev(t + 42, 7'b0000010, 2'b00, NOTE_RE, 1'b1, 1'b0);
    expect_ev(t + 43, 7'b0000010, 2'b00, NOTE_RE, 1'b0, 1'b0);
    expect_ev(t + 74, 7'b0000010, 2'b00, NOTE_RE, 1'b1, 1'b0);
    expect_ev(t + 75, 7'b0000010, 2'b00, NOTE_RE, 1'b0, 1'b0);
`endif
    step(90);
    t = cyc;
    kbd.key_raw = 7'b0;
    expect_ev(t + 10, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b1);
    expect_ev(t + 11, 7'b0, 2'b00, NOTE_NONE, 1'b0, 1'b0);
    step(25);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_key_conditioner.md
Name: note_key_conditioner

Overview:
Upstream front-end for the learning-play and free-play stages. It conditions the raw board push-buttons: 7 note keys and 2 octave keys. Each key is synchronized and debounced, and the block produces a clean key vector, an encoded note code (0 = none, 1..7 = do..ti), and one-cycle press/release strobes. Its outputs replace direct button wiring into the scoring, LED-hint and buzzer logic.

Parameters:
DEBOUNCE_CYCLES, 2_000_000, consecutive stable cycles required before a key change is accepted (20 ms at 100 MHz); minimum 2.
SYNC_STAGES, 2, flip-flop depth of the input synchronizer; minimum 2.
REPEAT_CYCLES, 25_000_000, auto-repeat period; used only when KEY_REPEAT_EN is defined.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_raw  in  7  raw note buttons, bit0 = do … bit6 = ti, active-high
octave_raw  in  2  raw octave buttons, bit0 = down, bit1 = up
key_stable  out  7  debounced note key vector
octave_stable  out  2  debounced octave key vector
note_code  out  4  encoded held note: 0 = none, 1..7 = lowest-index held key
press_pulse  out  1  one-cycle strobe when a note key becomes held
release_pulse  out  1  one-cycle strobe when key_stable becomes all-zero
any_key  out  1  OR of key_stable

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: all outputs 0; synchronizers 0; counters 0; every key cell in RELEASED.
- Synchronizer: each of the 9 raw bits passes through SYNC_STAGES flops.
- Per-key cell FSM: RELEASED -> ARMING -> HELD -> DISARMING -> RELEASED.
  - RELEASED: synced=1 moves to ARMING and clears the counter.
  - ARMING: synced=0 returns to RELEASED (bounce rejected). Otherwise the counter increments; when counter = DEBOUNCE_CYCLES-1, go to HELD and set the stable bit.
  - HELD: synced=0 moves to DISARMING and clears the counter.
  - DISARMING: synced=1 returns to HELD. When counter = DEBOUNCE_CYCLES-1, go to RELEASED and clear the stable bit.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter saturates and never wraps.
- Latency: a clean raw edge reaches key_stable/octave_stable SYNC_STAGES+DEBOUNCE_CYCLES cycles later. A pulse shorter than DEBOUNCE_CYCLES never changes key_stable.
- All outputs are registered. press_pulse, release_pulse and note_code update in the same cycle as key_stable.
- press_pulse: 1 for exactly one cycle when any key_stable bit rises. Several bits rising in the same cycle give a single pulse.
- release_pulse: 1 for exactly one cycle when key_stable goes from nonzero to zero.
- note_code: index+1 of the lowest set bit of key_stable; 0 when key_stable is 0. Releasing the lowest held key while others remain held updates note_code with no pulse.
- Octave keys use the same cell and produce no strobes. Both octave bits set is passed through unchanged; the octave control downstream resolves it.
- Reset mid-debounce discards all partial counts. No pulse is emitted on reset deassertion, even if keys are physically held; those keys then debounce from RELEASED.

Optional Feature:
KEY_REPEAT_EN
- Defined: while note_code stays nonzero and unchanged, press_pulse reasserts for one cycle every REPEAT_CYCLES cycles after the initial press. The repeat timer restarts on any change of note_code and clears on release.
- Undefined: no repeat timer is synthesized; press_pulse fires only on rising key_stable bits. REPEAT_CYCLES is ignored.

Decomposition:
- Package keyboard_pkg holds:
  - note code constants NOTE_NONE=4'd0 … NOTE_TI=4'd7
  - NUM_NOTE_KEYS=7, NUM_OCT_KEYS=2
  - default DEBOUNCE_CYCLES
  - the cell state enum (RELEASED, ARMING, HELD, DISARMING)
- Sub-module key_debounce_cell holds one synchronizer, one counter and one FSM, with 1-bit in and 1-bit stable out. It is instantiated 9 times.
- The top level adds the encoder, the edge/strobe logic and the optional repeat timer.

Test Plan (bench uses DEBOUNCE_CYCLES=8, SYNC_STAGES=2, REPEAT_CYCLES=32):
- Reset, then key_raw=7'b0000100 held 20 cycles -> key_stable=7'b0000100 and note_code=3 at cycle 10 after the edge; press_pulse high exactly one cycle.
- key_raw bit0 toggled every 3 cycles for 40 cycles -> key_stable stays 0; no pulses.
- Keys 5 and 2 pressed in the same cycle -> one press_pulse, note_code=3. Release key 2 -> note_code=6, no pulse. Release key 5 -> note_code=0 and one release_pulse 10 cycles later.
- Key held to HELD, then a 4-cycle low glitch -> key_stable stays 1; no release_pulse.
- reset asserted asynchronously mid-ARMING, deasserted while the key is still held -> outputs 0 immediately; key_stable rises 10 cycles after deassert with one press_pulse.
- With KEY_REPEAT_EN, key 1 held 100 cycles -> press_pulses at the press cycle, +32 and +64. Without the macro -> single pulse only.
